sram_bridge: RTL and testbench

Bus-to-SRAM bridge that turns one 32-bit load/store request from the load-store unit into one or two 16-bit transactions on the board's asynchronous SRAM. It sits directly downstream of the LSU and serves the data-memory window 0x2000–0x3FFF. Byte, halfword and word accesses are formatted with byte lanes and sign or zero extension. Completion is signalled with a single-cycle ack, which the core uses to release its stall.

---
 rtl/sram_bridge_pkg.sv | 27 ++
 rtl/sram_ld_align.sv | 27 ++
 rtl/sram_bridge.sv | 143 ++++++++++++++
 tb/tb_sram_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the LSU-to-async-SRAM bridge.
// Window decode uses i_addr[15:12]; funct3 encodings follow the LSU.
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P0A,
        ST_P0B,
        ST_P1A,
        ST_P1B,
        ST_ACK
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] SRAM_WIN_LO = 4'h2;
    localparam logic [3:0] SRAM_WIN_HI = 4'h3;

    function automatic logic in_window(input logic [3:0] page);
        return (page == SRAM_WIN_LO) || (page == SRAM_WIN_HI);
    endfunction

endpackage

// File: rtl/sram_ld_align.sv
// Load formatter: picks the byte/halfword lane from the assembled word
// and applies sign or zero extension according to funct3.
module sram_ld_align
    import sram_bridge_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [2:0]  control,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = data[{addr, 3'b000} +: 8];
        half_v = addr[1] ? data[31:16] : data[15:0];
        case (control)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_BU:   result = {24'h0, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_HU:   result = {16'h0, half_v};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/sram_bridge.sv
// Bridges one 32-bit LSU load/store into one or two 16-bit async SRAM cycles.
// Pins are registered from the current state, so they trail the FSM by one cycle.
//
// state | meaning
// IDLE  | waiting for a window hit; latches the request on acceptance
// P0A   | first halfword, setup (address/lanes/data launched)
// P0B   | first halfword, strobe (WE_N low on writes)
// P1A   | second halfword of a word, setup
// P1B   | second halfword of a word, strobe
// ACK   | release strobes, emit the ack pulse, capture load result
module sram_bridge
    import sram_bridge_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_wren,
    input  logic        i_rden,
    input  logic [2:0]  i_control,
    output logic [31:0] o_rd_data,
    output logic        o_ack,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    state_t state, state_next;

    logic [12:0] addr_q;
    logic [31:0] st_q;
    logic [2:0]  ctl_q;
    logic        wr_q;
    logic [15:0] asm_lo;
    logic        drive_en;
    logic [15:0] dq_out;

    logic        hit, word_q, byte_q, phase1, strobe_b, h;
    logic        ce_d, we_d, oe_d, lb_d, ub_d, drive_d;
    logic [17:0] addr_d;
    logic [15:0] dq_d;
    logic [31:0] ld_word, ld_result;

    assign SRAM_DQ = drive_en ? dq_out : 'z;

    assign hit    = in_window(i_addr[15:12]) && (i_wren || i_rden);
    assign word_q = (ctl_q == F3_W);
    assign byte_q = (ctl_q[1:0] == 2'b00);
    assign phase1 = (state == ST_P1A) || (state == ST_P1B);
    assign strobe_b = (state == ST_P0B) || (state == ST_P1B);
    assign h      = word_q ? phase1 : addr_q[1];

    // Final halfword is taken straight off the bus so the result registers on the ACK edge.
    assign ld_word = word_q  ? {SRAM_DQ, asm_lo} :
                     addr_q[1] ? {SRAM_DQ, 16'h0} : {16'h0, SRAM_DQ};

    sram_ld_align u_align (
        .data    (ld_word),
        .addr    (addr_q[1:0]),
        .control (ctl_q),
        .result  (ld_result)
    );

    always_comb begin
        state_next = state;
        ce_d    = 1'b1;
        we_d    = 1'b1;
        oe_d    = 1'b1;
        lb_d    = 1'b1;
        ub_d    = 1'b1;
        drive_d = 1'b0;
        addr_d  = SRAM_ADDR;
        dq_d    = dq_out;
        case (state)
            ST_IDLE: if (hit) state_next = ST_P0A;
            ST_P0A:  state_next = ST_P0B;
            ST_P0B:  state_next = word_q ? ST_P1A : ST_ACK;
            ST_P1A:  state_next = ST_P1B;
            ST_P1B:  state_next = ST_ACK;
            default: state_next = ST_IDLE;
        endcase
        if (state inside {ST_P0A, ST_P0B, ST_P1A, ST_P1B}) begin
            ce_d    = 1'b0;
            oe_d    = wr_q;
            we_d    = !(wr_q && strobe_b);
            lb_d    = byte_q && addr_q[0];
            ub_d    = byte_q && !addr_q[0];
            drive_d = wr_q;
            addr_d  = {6'b0, addr_q[12:2], h};
            if (byte_q)
                dq_d = {st_q[7:0], st_q[7:0]};
            else
                dq_d = phase1 ? st_q[31:16] : st_q[15:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            st_q      <= '0;
            ctl_q     <= '0;
            wr_q      <= 1'b0;
            asm_lo    <= '0;
            o_ack     <= 1'b0;
            o_rd_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            drive_en  <= 1'b0;
            dq_out    <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && hit) begin
                addr_q <= i_addr[12:0];
                st_q   <= i_st_data;
                ctl_q  <= i_control;
                wr_q   <= i_wren;
            end
            o_ack     <= (state == ST_ACK);
            SRAM_ADDR <= addr_d;
            SRAM_CE_N <= ce_d;
            SRAM_WE_N <= we_d;
            SRAM_OE_N <= oe_d;
            SRAM_LB_N <= lb_d;
            SRAM_UB_N <= ub_d;
            drive_en  <= drive_d;
            dq_out    <= dq_d;
            if (!wr_q && state == ST_P1A)
                asm_lo <= SRAM_DQ;
            if (!wr_q && state == ST_ACK)
                o_rd_data <= ld_result;
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: async SRAM model on the pins, byte-level reference
// memory for load results, and a per-cycle compare of ack/rd_data/strobes.
module tb_sram_bridge;
    import sram_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [31:0] st;
    logic        wren, rden;
    logic [2:0]  ctl;
    wire  [31:0] rd_data;
    wire         ack;
    wire  [17:0] s_addr;
    wire  [15:0] s_dq;
    wire         ce_n, we_n, oe_n, lb_n, ub_n;

    sram_bridge dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_st_data(st),
        .i_wren(wren), .i_rden(rden), .i_control(ctl),
        .o_rd_data(rd_data), .o_ack(ack),
        .SRAM_ADDR(s_addr), .SRAM_DQ(s_dq),
        .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Async SRAM: drives the bus while selected and output-enabled, writes lanes while WE_N is low.
    logic [15:0] sram [0:4095];
    logic [17:0] wl_addr [$];
    logic [15:0] wl_data [$];
    logic [1:0]  wl_lane [$];

    assign s_dq = (!ce_n && !oe_n && we_n) ? sram[s_addr[11:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) sram[s_addr[11:0]][7:0]  = s_dq[7:0];
            if (!ub_n) sram[s_addr[11:0]][15:8] = s_dq[15:8];
            wl_addr.push_back(s_addr);
            wl_data.push_back(s_dq);
            wl_lane.push_back({ub_n, lb_n});
        end
    end

    // Reference: byte-addressed view of the 8 KB window.
    logic [7:0] mref [0:8191];

    function automatic logic [31:0] m_load(input logic [15:0] a, input logic [2:0] f);
        int b;
        logic [7:0]  by;
        logic [15:0] hw;
        b = int'(a[12:0]);
        case (f[1:0])
            2'b00: begin
                by = mref[b];
                return f[2] ? {24'h0, by} : {{24{by[7]}}, by};
            end
            2'b01: begin
                b  = b & ~1;
                hw = {mref[b+1], mref[b]};
                return f[2] ? {16'h0, hw} : {{16{hw[15]}}, hw};
            end
            default: begin
                b = b & ~3;
                return {mref[b+3], mref[b+2], mref[b+1], mref[b]};
            end
        endcase
    endfunction

    task automatic m_store(input logic [15:0] a, input logic [31:0] d, input logic [2:0] f);
        int b;
        b = int'(a[12:0]);
        case (f[1:0])
            2'b00: mref[b] = d[7:0];
            2'b01: begin
                b = b & ~1;
                mref[b] = d[7:0]; mref[b+1] = d[15:8];
            end
            default: begin
                b = b & ~3;
                mref[b] = d[7:0];   mref[b+1] = d[15:8];
                mref[b+2] = d[23:16]; mref[b+3] = d[31:24];
            end
        endcase
    endtask

    logic        run = 1'b0;
    logic        busy = 1'b0;
    int          exp_ack_cyc = -1;
    logic        exp_load = 1'b0;
    logic [31:0] exp_val = '0;
    logic [31:0] model_rd = '0;

    always @(negedge clk) begin
        if (run) begin
            if (rst)
                model_rd = '0;
            else if (cyc == exp_ack_cyc && exp_load)
                model_rd = exp_val;
            chk("ack_timing", {31'b0, ack}, {31'b0, (cyc == exp_ack_cyc)});
            chk("rd_data", rd_data, model_rd);
            if (!busy)
                chk("idle_strobes", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1f);
            if (!we_n)
                chk("we_without_oe", {31'b0, oe_n}, 32'h1);
            if (!ce_n)
                chk("addr_upper_zero", {26'b0, s_addr[17:12]}, 32'h0);
        end
    end

    task automatic do_req(input logic [15:0] a, input logic [31:0] d, input logic w,
                          input logic r, input logic [2:0] f,
                          output logic [31:0] res, output int lat);
        int  k;
        bit  got;
        k = cyc;
        addr = a; st = d; wren = w; rden = r; ctl = f;
        busy = 1'b1;
        exp_ack_cyc = k + 1 + ((f == F3_W) ? 5 : 3);
        if (w) begin
            m_store(a, d, f);
            exp_load = 1'b0;
        end else begin
            exp_val  = m_load(a, f);
            exp_load = 1'b1;
        end
        got = 1'b0;
        res = '0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                res = rd_data;
                lat = cyc - (k + 1);
                break;
            end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL ack_timeout addr=%h actual=no_ack required=ack", a);
        end
        #2;
        wren = 1'b0; rden = 1'b0;
        busy = 1'b0;
        exp_ack_cyc = -1;
    endtask

    logic [31:0] res;
    int          lat, base, acks;

    initial begin
        rst = 1'b1; addr = 16'h2000; st = '0; wren = 1'b0; rden = 1'b1; ctl = F3_W;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1f);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_addr", {14'b0, s_addr}, 32'h0);
        #2 rden = 1'b0; addr = '0;
        @(negedge clk);
        #2 rst = 1'b0; run = 1'b1;

        base = wl_addr.size();
        do_req(16'h2004, 32'hDEADBEEF, 1, 0, F3_W, res, lat);
        chk("sw_lat", lat, 5);
        chk("sw_nwr", wl_addr.size() - base, 2);
        if (wl_addr.size() - base == 2) begin
            chk("sw_a0", {14'b0, wl_addr[base]}, 32'h002);
            chk("sw_d0", {16'b0, wl_data[base]}, 32'hBEEF);
            chk("sw_l0", {30'b0, wl_lane[base]}, 32'h0);
            chk("sw_a1", {14'b0, wl_addr[base+1]}, 32'h003);
            chk("sw_d1", {16'b0, wl_data[base+1]}, 32'hDEAD);
        end
        do_req(16'h2004, 0, 0, 1, F3_W, res, lat);
        chk("lw_val", res, 32'hDEADBEEF);
        chk("lw_lat", lat, 5);

        base = wl_addr.size();
        do_req(16'h2007, 32'h000000A5, 1, 0, F3_B, res, lat);
        chk("sb_lat", lat, 3);
        chk("sb_nwr", wl_addr.size() - base, 1);
        if (wl_addr.size() - base == 1) begin
            chk("sb_a", {14'b0, wl_addr[base]}, 32'h003);
            chk("sb_d", {16'b0, wl_data[base]}, 32'hA5A5);
            chk("sb_lanes_ub_lb", {30'b0, wl_lane[base]}, 32'h1);
        end
        do_req(16'h2007, 0, 0, 1, F3_B, res, lat);
        chk("lb_val", res, 32'hFFFFFFA5);
        chk("lb_lat", lat, 3);
        do_req(16'h2007, 0, 0, 1, F3_BU, res, lat);
        chk("lbu_val", res, 32'h000000A5);
        do_req(16'h2006, 0, 0, 1, F3_BU, res, lat);
        chk("lbu_neighbour", res, 32'h000000AD);
        do_req(16'h2005, 0, 0, 1, F3_B, res, lat);
        chk("lb_2005", res, 32'hFFFFFFBE);
        do_req(16'h2007, 0, 0, 1, F3_HU, res, lat);
        chk("lhu_upper_half", res, 32'h0000A5AD);

        base = wl_addr.size();
        do_req(16'h3002, 32'h00008001, 1, 0, F3_H, res, lat);
        chk("sh_lat", lat, 3);
        chk("sh_nwr", wl_addr.size() - base, 1);
        if (wl_addr.size() - base == 1) begin
            chk("sh_a", {14'b0, wl_addr[base]}, 32'h801);
            chk("sh_d", {16'b0, wl_data[base]}, 32'h8001);
        end
        do_req(16'h3002, 0, 0, 1, F3_H, res, lat);
        chk("lh_val", res, 32'hFFFF8001);
        do_req(16'h3003, 0, 0, 1, F3_HU, res, lat);
        chk("lhu_val", res, 32'h00008001);

        base = wl_addr.size();
        addr = 16'h7000; st = 32'h11111111; wren = 1'b1; rden = 1'b1; ctl = F3_W;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) acks++;
        end
        #2 wren = 1'b0; rden = 1'b0;
        chk("miss_ack", acks, 0);
        chk("miss_nwr", wl_addr.size() - base, 0);

        base = wl_addr.size();
        do_req(16'h2000, 32'h12345678, 1, 1, F3_W, res, lat);
        chk("prio_nwr", wl_addr.size() - base, 2);
        do_req(16'h2000, 0, 0, 1, F3_W, res, lat);
        chk("prio_lw", res, 32'h12345678);

        addr = 16'h2004; ctl = F3_W; rden = 1'b1; wren = 1'b0;
        busy = 1'b1; exp_ack_cyc = -1; exp_load = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_strobes", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1f);
        chk("midrst_ack", {31'b0, ack}, 32'h0);
        #2 rst = 1'b0; rden = 1'b0; busy = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        do_req(16'h2004, 0, 0, 1, F3_W, res, lat);
        chk("post_rst_lw", res, 32'hA5ADBEEF);
        chk("post_rst_lat", lat, 5);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
